// File: rtl/ml_pkg.sv
// Shared definitions for the ML soft demapper: FSM states, QPSK symbol/bit
// mapping and the all-ones metric constant used to seed minima.
package ml_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC,
      ST_RESOLVE,
      ST_OUT
   } state_t;

   localparam int unsigned METRIC_MAX_W = 32;
   localparam logic [METRIC_MAX_W-1:0] METRIC_ALL_ONES = '1;

   // QPSK symbol bit: b=0 is the real bit (symbol MSB), b=1 the imag bit (LSB)
   function automatic logic sym_bit(input logic [1:0] sym, input logic b);
      return b ? sym[0] : sym[1];
   endfunction

endpackage

// File: rtl/ml_min_tracker.sv
// Per-layer tracker: four per-symbol running minima, plus bit-wise M0/M1
// resolution into hard bits and saturated soft LLRs.
module ml_min_tracker
   import ml_pkg::*;
#(
   parameter int MW  = 22,
   parameter int LW  = 8,
   parameter int LSH = 4
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_clear,
   input  logic [3:0]      i_upd,
   input  logic [4*MW-1:0] i_metric,
   output logic [1:0]      o_hardbit,
   output logic [2*LW-1:0] o_llr
);

   localparam logic [MW-1:0]        MMAX   = METRIC_ALL_ONES[MW-1:0];
   localparam int                   LLR_HI = (1 << (LW-1)) - 1;
   localparam int                   LLR_LO = -(1 << (LW-1));
   localparam logic signed [MW:0]   SAT_HI = (MW+1)'(LLR_HI);
   localparam logic signed [MW:0]   SAT_LO = (MW+1)'(LLR_LO);

   logic [MW-1:0] min_q [4];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int unsigned s = 0; s < 4; s++) min_q[s] <= MMAX;
      end else if (i_clear) begin
         for (int unsigned s = 0; s < 4; s++) min_q[s] <= MMAX;
      end else begin
         for (int unsigned s = 0; s < 4; s++) begin
            if (i_upd[s] && (i_metric[s*MW +: MW] < min_q[s]))
               min_q[s] <= i_metric[s*MW +: MW];
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bit
      logic [MW-1:0]      m0, m1;
      logic signed [MW:0] d, sh;
      logic [LW-1:0]      llr;

      always_comb begin
         m0 = MMAX;
         m1 = MMAX;
         for (int unsigned s = 0; s < 4; s++) begin
            if (sym_bit(2'(s), 1'(b))) begin
               if (min_q[s] < m1) m1 = min_q[s];
            end else begin
               if (min_q[s] < m0) m0 = min_q[s];
            end
         end
      end

      // Metrics are unsigned, so one extra bit keeps M0-M1 exact before the floor shift
      assign d  = $signed({1'b0, m0}) - $signed({1'b0, m1});
      assign sh = d >>> LSH;

      always_comb begin
         if (sh > SAT_HI)      llr = SAT_HI[LW-1:0];
         else if (sh < SAT_LO) llr = SAT_LO[LW-1:0];
         else                  llr = sh[LW-1:0];
      end

      assign o_hardbit[b]        = (m1 < m0);
      assign o_llr[b*LW +: LW]   = llr;
   end

endmodule

// File: rtl/ml_soft_demap.sv
// Max-log ML soft demapper for NT QPSK layers: accumulates candidate metrics
// into per-layer minima, then resolves registered hard bits and soft LLRs.
module ml_soft_demap
   import ml_pkg::*;
#(
   parameter int NT  = 4,
   parameter int MW  = 22,
   parameter int LW  = 8,
   parameter int LSH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_start,
   input  logic                  i_cand_valid,
   output logic                  o_cand_ready,
   input  logic [2*(NT-1)-1:0]   i_cand_idx,
   input  logic [4*MW-1:0]       i_metric,
   input  logic                  i_cand_last,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [2*NT-1:0]       o_hardbit,
   output logic [2*NT*LW-1:0]    o_llr,
   output logic                  o_cnt_err,
   output logic                  o_busy
);

   localparam int            CW      = 2*(NT-1) + 1;
   localparam logic [CW-1:0] CNT_EXP = {1'b1, {(CW-1){1'b0}}};

   state_t             state_q, state_d;
   logic               accept, clear;
   logic [CW-1:0]      cnt_q;
   logic [MW-1:0]      m_all;
   logic [2*NT-1:0]    hb_w;
   logic [2*NT*LW-1:0] llr_w;

   always_comb begin
      m_all = i_metric[MW-1:0];
      for (int unsigned s = 1; s < 4; s++) begin
         if (i_metric[s*MW +: MW] < m_all) m_all = i_metric[s*MW +: MW];
      end
   end

   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               clear   = 1'b1;
               state_d = ST_ACC;
            end
         end
         ST_ACC: begin
            // A restart takes priority and drops any candidate offered alongside it
            if (i_start) begin
               clear = 1'b1;
            end else if (i_cand_valid) begin
               accept = 1'b1;
               if (i_cand_last) state_d = ST_RESOLVE;
            end
         end
         ST_RESOLVE: state_d = ST_OUT;
         ST_OUT: begin
            if (i_ready) begin
               if (i_start) begin
                  clear   = 1'b1;
                  state_d = ST_ACC;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   for (genvar k = 0; k < NT; k++) begin : g_layer
      logic [3:0]      upd;
      logic [4*MW-1:0] met;

      if (k == 0) begin : g_l0
         assign upd = {4{accept}};
         assign met = i_metric;
      end else begin : g_lk
         assign upd = accept ? (4'b0001 << i_cand_idx[2*(k-1) +: 2]) : 4'b0000;
         assign met = {4{m_all}};
      end

      ml_min_tracker #(
         .MW  (MW),
         .LW  (LW),
         .LSH (LSH)
      ) u_trk (
         .i_clk     (i_clk),
         .i_reset_n (i_reset_n),
         .i_clear   (clear),
         .i_upd     (upd),
         .i_metric  (met),
         .o_hardbit (hb_w[2*k +: 2]),
         .o_llr     (llr_w[2*k*LW +: 2*LW])
      );
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         o_hardbit <= '0;
         o_llr     <= '0;
         o_cnt_err <= 1'b0;
      end else begin
         state_q <= state_d;
         if (clear)                        cnt_q <= '0;
         else if (accept && cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
         if (state_q == ST_RESOLVE) begin
            o_hardbit <= hb_w;
            o_llr     <= llr_w;
            o_cnt_err <= (cnt_q != CNT_EXP);
         end
      end
   end

   assign o_cand_ready = (state_q == ST_ACC);
   assign o_valid      = (state_q == ST_OUT);
   assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ml_soft_demap.sv
// Directed bench for ml_soft_demap (NT=4, MW=22, LW=8, LSH=4) with
// hand-computed hard bits, LLRs, count-error flag and handshake timing.
module tb_ml_soft_demap;

   localparam int NT  = 4;
   localparam int MW  = 22;
   localparam int LW  = 8;
   localparam int LSH = 4;

   localparam logic [5:0]    WIN_IDX = 6'b01_10_11;
   localparam logic [MW-1:0] BIG     = 22'd4194303;

   logic                 i_clk = 1'b0;
   logic                 i_reset_n;
   logic                 i_start;
   logic                 i_cand_valid;
   logic                 o_cand_ready;
   logic [2*(NT-1)-1:0]  i_cand_idx;
   logic [4*MW-1:0]      i_metric;
   logic                 i_cand_last;
   logic                 o_valid;
   logic                 i_ready;
   logic [2*NT-1:0]      o_hardbit;
   logic [2*NT*LW-1:0]   o_llr;
   logic                 o_cnt_err;
   logic                 o_busy;

   int total = 0;
   int bad   = 0;

   always #5 i_clk = ~i_clk;

   ml_soft_demap #(
      .NT  (NT),
      .MW  (MW),
      .LW  (LW),
      .LSH (LSH)
   ) dut (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_start      (i_start),
      .i_cand_valid (i_cand_valid),
      .o_cand_ready (o_cand_ready),
      .i_cand_idx   (i_cand_idx),
      .i_metric     (i_metric),
      .i_cand_last  (i_cand_last),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_hardbit    (o_hardbit),
      .o_llr        (o_llr),
      .o_cnt_err    (o_cnt_err),
      .o_busy       (o_busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] llr_vec(input logic [7:0] hb, input logic [7:0] pos,
                                           input logic [7:0] neg);
      logic [63:0] v;
      v = '0;
      for (int j = 0; j < 8; j++) v[j*8 +: 8] = hb[j] ? pos : neg;
      return v;
   endfunction

   // Enter ACC from IDLE; returns at the negedge following the start edge
   task automatic start_search(input string tag);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      check({tag, ".acc_ready"}, 64'(o_cand_ready), 64'd1);
   endtask

   // Offer candidates idx 0..n-1, one per cycle; winner idx carries wm on symbol 2
   task automatic feed(input int n, input logic [MW-1:0] wm, input logic [MW-1:0] om,
                       input bit last_on_final);
      for (int c = 0; c < n; c++) begin
         i_cand_valid = 1'b1;
         i_cand_idx   = 6'(c);
         i_cand_last  = last_on_final && (c == n-1);
         for (int s = 0; s < 4; s++)
            i_metric[s*MW +: MW] = (6'(c) == WIN_IDX && s == 2) ? wm : om;
         @(negedge i_clk);
      end
      i_cand_valid = 1'b0;
      i_cand_last  = 1'b0;
   endtask

   // Called one cycle after the last accept; result must appear the next cycle
   task automatic finish_check(input string tag, input logic [7:0] hb, input logic [63:0] llr,
                               input logic err);
      check({tag, ".resolve_valid"}, 64'(o_valid), 64'd0);
      check({tag, ".resolve_busy"},  64'(o_busy),  64'd1);
      @(negedge i_clk);
      check({tag, ".out_valid"}, 64'(o_valid),   64'd1);
      check({tag, ".hardbit"},   64'(o_hardbit), 64'(hb));
      check({tag, ".llr"},       o_llr,          llr);
      check({tag, ".cnt_err"},   64'(o_cnt_err), 64'(err));
   endtask

   task automatic release_out(input string tag);
      i_ready = 1'b1;
      @(negedge i_clk);
      i_ready = 1'b0;
      check({tag, ".idle_busy"},  64'(o_busy),  64'd0);
      check({tag, ".idle_valid"}, 64'(o_valid), 64'd0);
   endtask

   logic [63:0] llr_a;
   logic [63:0] llr_b;

   initial begin
      llr_a = llr_vec(8'h9D, 8'd61, 8'hC2);
      llr_b = llr_vec(8'h9D, 8'h7F, 8'h80);

      i_reset_n    = 1'b0;
      i_start      = 1'b0;
      i_cand_valid = 1'b0;
      i_cand_last  = 1'b0;
      i_cand_idx   = '0;
      i_metric     = '0;
      i_ready      = 1'b0;
      repeat (2) @(negedge i_clk);
      check("rst.valid",   64'(o_valid),      64'd0);
      check("rst.busy",    64'(o_busy),       64'd0);
      check("rst.ready",   64'(o_cand_ready), 64'd0);
      check("rst.hardbit", 64'(o_hardbit),    64'd0);
      check("rst.llr",     o_llr,             64'd0);
      check("rst.cnt_err", 64'(o_cnt_err),    64'd0);
      i_reset_n = 1'b1;
      @(negedge i_clk);

      // Single winner at idx 01_10_11, symbol 2; start held through RESOLVE/OUT stall
      start_search("a");
      feed(64, 22'd10, 22'd1000, 1'b1);
      i_start = 1'b1;
      finish_check("a", 8'h9D, llr_a, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         check("a.stall_valid", 64'(o_valid),      64'd1);
         check("a.stall_hb",    64'(o_hardbit),    64'h9D);
         check("a.stall_llr",   o_llr,             llr_a);
         check("a.stall_ready", 64'(o_cand_ready), 64'd0);
      end
      i_ready = 1'b1;
      @(negedge i_clk);
      i_ready = 1'b0;
      i_start = 1'b0;
      check("a.restart_ready", 64'(o_cand_ready), 64'd1);
      check("a.restart_valid", 64'(o_valid),      64'd0);

      // Equal metrics everywhere: ties give zero bits and zero LLRs (minima must have reset)
      feed(64, 22'd500, 22'd500, 1'b1);
      finish_check("tie", 8'h00, 64'd0, 1'b0);
      release_out("tie");

      // Extreme metrics drive both saturation limits
      start_search("sat");
      feed(64, 22'd0, BIG, 1'b1);
      finish_check("sat", 8'h9D, llr_b, 1'b0);
      release_out("sat");

      // Restart after 20 candidates; the restart-cycle candidate (zero metrics, last) is dropped
      start_search("rs");
      feed(20, 22'd10, 22'd1000, 1'b0);
      i_start      = 1'b1;
      i_cand_valid = 1'b1;
      i_cand_last  = 1'b1;
      i_cand_idx   = '0;
      i_metric     = '0;
      @(negedge i_clk);
      i_start      = 1'b0;
      i_cand_valid = 1'b0;
      i_cand_last  = 1'b0;
      check("rs.still_acc", 64'(o_cand_ready), 64'd1);
      feed(64, 22'd10, 22'd1000, 1'b1);
      finish_check("rs", 8'h9D, llr_a, 1'b0);
      release_out("rs");

      // Short search: 63 candidates flags a count error
      start_search("short");
      feed(63, 22'd10, 22'd1000, 1'b1);
      finish_check("short", 8'h9D, llr_a, 1'b1);
      release_out("short");

      // Asynchronous reset mid-ACC, then a clean tie search must see fresh minima
      start_search("ar");
      feed(10, 22'd0, 22'd0, 1'b0);
      #1 i_reset_n = 1'b0;
      #1;
      check("ar.busy",  64'(o_busy),       64'd0);
      check("ar.valid", 64'(o_valid),      64'd0);
      check("ar.ready", 64'(o_cand_ready), 64'd0);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      start_search("ar2");
      feed(64, 22'd500, 22'd500, 1'b1);
      finish_check("ar2", 8'h00, 64'd0, 1'b0);
      release_out("ar2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ml_soft_demap.md
ML_SOFT_DEMAP -- requirements
Module: ml_soft_demap

Interface
REQ-001 SHALL have parameter NT, default 4, number of QPSK layers (legal 2..4).
REQ-002 SHALL have parameter MW, default 22, unsigned metric width.
REQ-003 SHALL have parameter LW, default 8, signed soft-LLR output width.
REQ-004 SHALL have parameter LSH, default 4, arithmetic right shift applied before LLR saturation.
REQ-005 SHALL have port i_clk  in  1  sole clock; all state rising-edge.
REQ-006 SHALL have port i_reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port i_start  in  1  begin new search, clear minima.
REQ-008 SHALL have port i_cand_valid  in  1  candidate present.
REQ-009 SHALL have port o_cand_ready  out  1  candidate accepted when valid&ready.
REQ-010 SHALL have port i_cand_idx  in  2*(NT-1)  symbols of layers 1..NT-1, layer k in [2(k-1)+:2].
REQ-011 SHALL have port i_metric  in  4*MW  layer-0 symbol s metric in [s*MW+:MW].
REQ-012 SHALL have port i_cand_last  in  1  final candidate of search.
REQ-013 SHALL have port o_valid  out  1  result available.
REQ-014 SHALL have port i_ready  in  1  downstream accepts result.
REQ-015 SHALL have port o_hardbit  out  2*NT  bit 2k = layer-k real (symbol MSB), bit 2k+1 = imag (LSB).
REQ-016 SHALL have port o_llr  out  2*NT*LW  soft LLR j in [j*LW+:LW], same bit order as o_hardbit.
REQ-017 SHALL have port o_cnt_err  out  1  accepted-candidate count != 4^(NT-1).
REQ-018 SHALL have port o_busy  out  1  state != IDLE.

Function
REQ-019 SHALL implement FSM IDLE, ACC, RESOLVE, OUT; o_cand_ready = 1 only in ACC.
REQ-020 IDLE: i_start -> ACC; all minima load 2^MW-1; candidate counter loads 0.
REQ-021 ACC, per accepted candidate: layer-0 min[s] = min(min[s], metric[s]) for s=0..3.
REQ-022 ACC, layers k>=1: m = min of four metrics; min_k[i_cand_idx field k] = min(stored, m); other symbols unchanged.
REQ-023 ACC: counter increments per accepted candidate, width 2*(NT-1)+1, saturating at all-ones.
REQ-024 Accepted candidate with i_cand_last -> RESOLVE next cycle; that candidate SHALL update minima.
REQ-025 i_start in ACC SHALL restart: minima/counter reinitialised, same-cycle candidate discarded, stay ACC.
REQ-026 RESOLVE (one cycle): per bit, M1 = min over symbols with bit=1, M0 = min over bit=0; d = M0 - M1 as MW+1-bit signed.
REQ-027 Hard bit SHALL be 1 iff M1 < M0; ties give 0.
REQ-028 LLR SHALL be d >>> LSH (floor), saturated to [-2^(LW-1), 2^(LW-1)-1].
REQ-029 RESOLVE -> OUT; o_valid=1 in OUT with o_hardbit, o_llr, o_cnt_err registered and stable until i_ready.
REQ-030 Latency: last candidate accepted cycle T -> o_valid high cycle T+2.
REQ-031 OUT with i_ready=1 -> IDLE, or -> ACC if i_start=1 same cycle; i_start in OUT otherwise ignored.
REQ-032 i_start in RESOLVE SHALL be ignored; unaccepted i_cand_* SHALL be ignored.
REQ-033 Never-visited symbol keeps 2^MW-1 and participates in REQ-026 unchanged.

Reset
REQ-034 On i_reset_n=0, immediately: state IDLE, o_valid 0, o_hardbit 0, o_llr 0, o_cnt_err 0, counter 0, minima 2^MW-1.
REQ-035 Reset mid-search SHALL discard the search with no output; first i_start after release behaves as REQ-020.

Structure
REQ-036 Shared package ml_pkg SHALL hold FSM state enum, QPSK symbol-to-bit mapping and the metric-max constant.
REQ-037 One sub-module ml_min_tracker (four per-symbol minima, update, bit-wise M0/M1, LLR/saturation) SHALL be instanced once per layer.

Verification (NT=4, MW=22, LW=8, LSH=4)
REQ-038 64 candidates, all metrics 1000 except idx=6'b01_10_11 metric[2]=10, last on 64th -> o_hardbit 0x9D, LLR +61 on 1-bits, -62 on 0-bits, o_cnt_err 0, o_valid at T+2.
REQ-039 Same but winner 0, others 4194303 -> LLRs +127 / -128.
REQ-040 All metrics 500 -> o_hardbit 0x00, all LLR 0.
REQ-041 i_ready low 5 cycles in OUT -> outputs stable, o_cand_ready 0; i_start with handshake -> ACC next cycle, minima reset.
REQ-042 i_start after 20 candidates then clean 64-candidate run -> identical to REQ-038; last after 63 -> o_cnt_err 1.
REQ-043 i_reset_n low mid-ACC -> IDLE, o_valid 0, o_busy 0 same cycle.
